// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr multiplexer family.
package stream_mux_pkg;

   localparam int unsigned MODE_SEL = 0;
   localparam int unsigned MODE_RR  = 1;

   // Index width for n channels, never narrower than one bit.
   function automatic int unsigned sel_idx_w(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping at N.
// The pointer moves past the granted channel only when advance is asserted.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = sel_idx_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          any_gnt
);

   logic [PW-1:0] ptr_q, ptr_d;

   // Two passes: lowest requester at or above ptr, else lowest below ptr.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any_gnt && req[i] && (PW'(i) >= ptr_q)) begin
            gnt[i]  = 1'b1;
            gnt_idx = PW'(i);
            any_gnt = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any_gnt && req[i] && (PW'(i) < ptr_q)) begin
            gnt[i]  = 1'b1;
            gnt_idx = PW'(i);
            any_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && any_gnt) begin
         ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// Channel choice is either an external select or round-robin arbitration.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MODE  = MODE_SEL,
   parameter int unsigned SEL_W = sel_idx_w(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [N_IN-1:0]       in_valid,
   output logic [N_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_src
);

   logic [N_IN-1:0]  gnt;
   logic [SEL_W-1:0] gnt_idx;
   logic             any_gnt;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] mux_data;

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [SEL_W-1:0] out_src_q;

   // Output register is empty or being drained this cycle.
   assign load_en = !out_valid_q || out_ready;
   assign xfer    = load_en && any_gnt;

   generate
      if (MODE == MODE_RR) begin : g_rr
         logic unused_sel;
         assign unused_sel = ^sel;

         rr_arbiter #(
            .N  (N_IN),
            .PW (SEL_W)
         ) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (in_valid),
            .advance (xfer),
            .gnt     (gnt),
            .gnt_idx (gnt_idx),
            .any_gnt (any_gnt)
         );
      end else begin : g_sel
         // A select value with no matching channel simply never grants.
         always_comb begin
            gnt     = '0;
            gnt_idx = '0;
            any_gnt = 1'b0;
            for (int i = 0; i < N_IN; i++) begin
               if ((sel == SEL_W'(i)) && in_valid[i]) begin
                  gnt[i]  = 1'b1;
                  gnt_idx = SEL_W'(i);
                  any_gnt = 1'b1;
               end
            end
         end
      end
   endgenerate

   assign in_ready = (rst_n && load_en) ? gnt : '0;

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (gnt[i]) begin
            mux_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else if (load_en) begin
         out_valid_q <= any_gnt;
         if (any_gnt) begin
            out_data_q <= mux_data;
            out_src_q  <= gnt_idx;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: select mode, round-robin mode, backpressure,
// a three-channel instance and asynchronous reset in the middle of a stream.
module tb_stream_mux_rr;

   logic clk;
   logic rst_n;

   // a: select mode, 4 channels
   logic [31:0] a_data;
   logic [3:0]  a_valid, a_ready;
   logic [1:0]  a_sel, a_src;
   logic [7:0]  a_odata;
   logic        a_ovalid, a_ordy;
   // b: round-robin, 4 channels
   logic [31:0] b_data;
   logic [3:0]  b_valid, b_ready;
   logic [1:0]  b_sel, b_src;
   logic [7:0]  b_odata;
   logic        b_ovalid, b_ordy;
   // c: select mode, 3 channels
   logic [23:0] c_data;
   logic [2:0]  c_valid, c_ready;
   logic [1:0]  c_sel, c_src;
   logic [7:0]  c_odata;
   logic        c_ovalid, c_ordy;
   // d: round-robin, 3 channels
   logic [23:0] d_data;
   logic [2:0]  d_valid, d_ready;
   logic [1:0]  d_sel, d_src;
   logic [7:0]  d_odata;
   logic        d_ovalid, d_ordy;

   int checks = 0;
   int errors = 0;

   stream_mux_rr #(.N_IN(4), .WIDTH(8), .MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
      .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_ordy), .out_src(a_src)
   );
   stream_mux_rr #(.N_IN(4), .WIDTH(8), .MODE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
      .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_ordy), .out_src(b_src)
   );
   stream_mux_rr #(.N_IN(3), .WIDTH(8), .MODE(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
      .sel(c_sel), .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_ordy), .out_src(c_src)
   );
   stream_mux_rr #(.N_IN(3), .WIDTH(8), .MODE(1)) dut_d (
      .clk(clk), .rst_n(rst_n), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
      .sel(d_sel), .out_data(d_odata), .out_valid(d_ovalid), .out_ready(d_ordy), .out_src(d_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        ordy;
      logic [3:0]  rdy;
      logic        ov;
      logic [7:0]  od;
      logic [1:0]  os;
   } vec_t;

   localparam logic [31:0] DA = 32'h77A5_2211;
   localparam logic [31:0] DB = 32'h4433_C33C;

   vec_t tbl[10];

   initial begin
      logic [3:0] e4;
      logic [2:0] e3;
      int         seq_skip[3];
      int         seq3[4];

      tbl[0] = '{2'd2, 4'b0100, DA, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
      tbl[1] = '{2'd3, 4'b0100, DA, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
      tbl[2] = '{2'd0, 4'b1111, DA, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      tbl[3] = '{2'd1, 4'b0010, DA, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
      tbl[4] = '{2'd3, 4'b1000, DB, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
      tbl[5] = '{2'd3, 4'b1000, DA, 1'b1, 4'b1000, 1'b1, 8'h77, 2'd3};
      tbl[6] = '{2'd1, 4'b0000, DA, 1'b0, 4'b0000, 1'b1, 8'h77, 2'd3};
      tbl[7] = '{2'd1, 4'b0000, DA, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
      tbl[8] = '{2'd1, 4'b0010, DB, 1'b0, 4'b0010, 1'b1, 8'hC3, 2'd1};
      tbl[9] = '{2'd1, 4'b0010, DB, 1'b1, 4'b0010, 1'b1, 8'hC3, 2'd1};
      seq_skip = '{3, 0, 3};
      seq3     = '{0, 1, 2, 0};

      a_data = '0; a_valid = 4'hF; a_sel = '0; a_ordy = 1'b1;
      b_data = '0; b_valid = 4'hF; b_sel = '0; b_ordy = 1'b1;
      c_data = '0; c_valid = '0;   c_sel = '0; c_ordy = 1'b1;
      d_data = '0; d_valid = '0;   d_sel = '0; d_ordy = 1'b1;
      rst_n  = 1'b0;

      // Reset state: ready must stay low even with valid inputs present.
      #2;
      check("rst_a_ready", 32'(a_ready), 32'h0);
      check("rst_b_ready", 32'(b_ready), 32'h0);
      check("rst_a_valid", 32'(a_ovalid), 32'h0);
      check("rst_a_data", 32'(a_odata), 32'h0);
      check("rst_a_src", 32'(a_src), 32'h0);
      #10;
      a_valid = '0; b_valid = '0;
      rst_n   = 1'b1;
      tick();

      // Select mode, table driven.
      for (int r = 0; r < 10; r++) begin
         a_sel = tbl[r].sel; a_valid = tbl[r].valid; a_data = tbl[r].data; a_ordy = tbl[r].ordy;
         #1;
         check($sformatf("m0_ready[%0d]", r), 32'(a_ready), 32'(tbl[r].rdy));
         tick();
         check($sformatf("m0_valid[%0d]", r), 32'(a_ovalid), 32'(tbl[r].ov));
         if (tbl[r].ov) begin
            check($sformatf("m0_data[%0d]", r), 32'(a_odata), 32'(tbl[r].od));
            check($sformatf("m0_src[%0d]", r), 32'(a_src), 32'(tbl[r].os));
         end
      end

      // Round robin, all channels valid: 0,1,2,3,0,1.
      b_data = 32'h1312_1110; b_valid = 4'hF; b_ordy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         e4 = 4'b0001 << (k % 4);
         #1;
         check($sformatf("rr_ready[%0d]", k), 32'(b_ready), 32'(e4));
         tick();
         check($sformatf("rr_valid[%0d]", k), 32'(b_ovalid), 32'h1);
         check($sformatf("rr_src[%0d]", k), 32'(b_src), 32'(k % 4));
         check($sformatf("rr_data[%0d]", k), 32'(b_odata), 32'(8'h10 + k % 4));
      end

      // Pointer is 2; a lone ch0 request moves it to 1.
      b_valid = 4'b0001;
      #1;
      check("rr_lone_ready", 32'(b_ready), 32'h1);
      tick();
      check("rr_lone_src", 32'(b_src), 32'h0);

      // Skip idle channels from ptr=1: 3, 0, 3.
      b_valid = 4'b1001;
      for (int k = 0; k < 3; k++) begin
         e4 = 4'b0001 << seq_skip[k];
         #1;
         check($sformatf("skip_ready[%0d]", k), 32'(b_ready), 32'(e4));
         tick();
         check($sformatf("skip_src[%0d]", k), 32'(b_src), 32'(seq_skip[k]));
      end

      // Backpressure: load 8'h11 from ch0 (ptr becomes 1), then stall 3 cycles.
      b_data = 32'h1413_1211; b_valid = 4'b0001;
      tick();
      check("bp_load_data", 32'(b_odata), 32'h11);
      b_ordy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         b_valid = 4'hF ^ 4'(k);
         #1;
         check($sformatf("bp_ready[%0d]", k), 32'(b_ready), 32'h0);
         tick();
         check($sformatf("bp_valid[%0d]", k), 32'(b_ovalid), 32'h1);
         check($sformatf("bp_data[%0d]", k), 32'(b_odata), 32'h11);
         check($sformatf("bp_src[%0d]", k), 32'(b_src), 32'h0);
      end
      b_ordy = 1'b1; b_valid = 4'hF;
      #1;
      check("bp_release_ready", 32'(b_ready), 32'b0010);
      tick();
      check("bp_release_data", 32'(b_odata), 32'h12);
      check("bp_release_src", 32'(b_src), 32'h1);
      b_valid = '0;
      tick();
      check("bp_drain_valid", 32'(b_ovalid), 32'h0);

      // Three channels, select mode: sel=3 never grants.
      c_data = 24'h33_2211; c_valid = 3'b111; c_sel = 2'd3;
      for (int k = 0; k < 2; k++) begin
         #1;
         check($sformatf("n3_sel3_ready[%0d]", k), 32'(c_ready), 32'h0);
         tick();
         check($sformatf("n3_sel3_valid[%0d]", k), 32'(c_ovalid), 32'h0);
      end
      c_sel = 2'd2;
      #1;
      check("n3_sel2_ready", 32'(c_ready), 32'b100);
      tick();
      check("n3_sel2_valid", 32'(c_ovalid), 32'h1);
      check("n3_sel2_data", 32'(c_odata), 32'h33);
      check("n3_sel2_src", 32'(c_src), 32'h2);

      // Three channels, round robin: 0,1,2,0.
      d_data = 24'h22_2120; d_valid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         e3 = 3'b001 << seq3[k];
         #1;
         check($sformatf("n3_rr_ready[%0d]", k), 32'(d_ready), 32'(e3));
         tick();
         check($sformatf("n3_rr_src[%0d]", k), 32'(d_src), 32'(seq3[k]));
         check($sformatf("n3_rr_data[%0d]", k), 32'(d_odata), 32'(8'h20 + seq3[k]));
      end

      // Asynchronous reset with a word held in dut_a and b's pointer at 2.
      a_ordy = 1'b0; a_valid = 4'hF; a_sel = 2'd0;
      b_valid = 4'hF; b_data = 32'h1312_1110;
      check("mid_pre_valid", 32'(a_ovalid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(a_ovalid), 32'h0);
      check("mid_rst_data", 32'(a_odata), 32'h0);
      check("mid_rst_src", 32'(a_src), 32'h0);
      check("mid_rst_a_ready", 32'(a_ready), 32'h0);
      check("mid_rst_b_ready", 32'(b_ready), 32'h0);
      tick();
      check("mid_rst_hold_valid", 32'(b_ovalid), 32'h0);
      #2;
      rst_n = 1'b1;
      #1;
      check("post_rst_b_ready", 32'(b_ready), 32'h1);
      tick();
      check("post_rst_b_src", 32'(b_src), 32'h0);
      check("post_rst_b_data", 32'(b_odata), 32'h10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
